dmem_store_buffer: RTL and testbench
====================================

// Module: dmem_store_buffer
// PURPOSE
//  Memory-side responder for the pipeline's MEM-stage data port. Queues stores
//  (address, data, byte-enable pattern) in a small FIFO and drains them one per
//  handshake to a single-write-port backing RAM. Loads return the combinational
//  RAM word merged byte-wise with pending buffered stores. Raises full so the
//  hazard unit can stall the pipeline.
// PARAMETERS
//  DEPTH  4   buffer entries; power of two, >=2
//  AW     32  address width (ADDR_SIZE)
//  DW     32  data width (XLEN); byte lanes = DW/8 = 4
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-high
//  addrM      in   AW  MEM-stage address (aluoutM); word = addrM[AW-1:2]
//  wdataM     in   DW  store data, already lane-aligned
//  memwriteM  in   1   store request this cycle
//  ampM       in   4   byte-enable pattern; bit i = lane i
//  rdataM     out  DW  load data, combinational, lane-aligned
//  full       out  1   buffer full; stores presented now are not accepted
//  ram_raddr  out  AW  = addrM, async read address of backing RAM
//  ram_rdata  in   DW  backing RAM read data for ram_raddr
//  ram_req    out  1   head entry valid, write requested
//  ram_ready  in   1   RAM accepts write this cycle
//  ram_addr   out  AW  head entry address, word-aligned ([1:0]=0)
//  ram_wdata  out  DW  head entry data
//  ram_be     out  4   head entry byte enables
// BEHAVIOUR
//  - Reset (async, any time, including mid-drain): count=0, wr_ptr=rd_ptr=0,
//    all entries invalid; ram_req=0, full=0, rdataM=ram_rdata. Queued stores lost.
//  - enq = memwriteM & (ampM!=0) & ~full. ampM==0 with memwriteM: no-op.
//  - deq = ram_req & ram_ready. ram_req = (count!=0); head outputs stable while
//    ram_req=1 and ram_ready=0.
//  - full = (count==DEPTH), registered-state derived; no enqueue when full even if
//    deq same cycle (store must be re-presented next cycle; pipeline stalls).
//  - enq & deq same cycle (not full): count unchanged, both pointers advance.
//  - Pointers wrap mod DEPTH; count range 0..DEPTH.
//  - Entry stores {addrM[AW-1:2],2'b00}, wdataM, ampM on clk edge of enq.
//  - No coalescing: two stores to one word occupy two entries, drain in order.
//  - Read merge, per lane i: from youngest valid entry with matching word address
//    and be[i]=1 -> its data lane i; else ram_rdata lane i. Entry being dequeued
//    this cycle still participates. Store enqueued this cycle is NOT forwarded.
//  - Latency: store visible to loads the cycle after enq; in RAM the cycle after deq.
//  - Block never reorders stores; RAM sees writes in program order.
// TESTING
//  1 Reset, ram_rdata=32'hAABBCCDD, addrM=0x10 -> rdataM=32'hAABBCCDD, ram_req=0,
//    full=0; assert reset mid-drain with count=3 -> count=0, ram_req=0 immediately.
//  2 ram_ready=0; sb 0x11 to 0x10 (amp=0001), then sh 0x2233 to 0x12 (amp=1100,
//    wdata=0x22330000); load 0x10 with ram_rdata=0 -> rdataM=32'h22330011.
//  3 Two sw to 0x20 (0x1111_1111 then 0x2222_2222) -> load 0x20 returns
//    0x2222_2222; ram_ready=1 -> RAM sees 0x1111_1111 then 0x2222_2222 in order.
//  4 ram_ready=0, five sw back-to-back, DEPTH=4 -> full=1 after 4th; 5th not
//    accepted, count stays 4; one deq + 5th re-presented -> accepted next cycle.
//  5 Steady enq+deq each cycle across 2*DEPTH stores -> pointers wrap, count constant
//    at 1, RAM write sequence equals store sequence.
//  6 memwriteM=1, ampM=0 -> no entry; store and load to 0x30 same cycle -> rdataM
//    is ram_rdata (no same-cycle forwarding).

Source files
------------

// File: rtl/dmem_store_buffer_if.sv
// MEM-stage data port plus backing-RAM side of the store buffer.
// The slave modport is the buffer itself; the master modport is the pipeline/RAM environment.
interface dmem_store_buffer_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [AW-1:0]   addrM;
   logic [DW-1:0]   wdataM;
   logic            memwriteM;
   logic [DW/8-1:0] ampM;
   logic [DW-1:0]   rdataM;
   logic            full;
   logic [AW-1:0]   ram_raddr;
   logic [DW-1:0]   ram_rdata;
   logic            ram_req;
   logic            ram_ready;
   logic [AW-1:0]   ram_addr;
   logic [DW-1:0]   ram_wdata;
   logic [DW/8-1:0] ram_be;

   modport slave (
      input  addrM, wdataM, memwriteM, ampM, ram_rdata, ram_ready,
      output rdataM, full, ram_raddr, ram_req, ram_addr, ram_wdata, ram_be
   );

   modport master (
      output addrM, wdataM, memwriteM, ampM, ram_rdata, ram_ready,
      input  rdataM, full, ram_raddr, ram_req, ram_addr, ram_wdata, ram_be
   );
endinterface

// File: rtl/dmem_store_buffer.sv
// In-order store buffer in front of a single-write-port data RAM.
// Loads see the RAM word with pending buffered stores merged in per byte lane.
module dmem_store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   dmem_store_buffer_if.slave    bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int NL = DW / 8;

   // Entries hold only the word address; the byte offset is always zero.
   logic [AW-3:0] waddr_mem [DEPTH];
   logic [DW-1:0] data_mem  [DEPTH];
   logic [NL-1:0] be_mem    [DEPTH];

   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [PW:0]   count_reg;
   logic          enq;
   logic          deq;

   // Slot holding the k-th oldest entry, and whether that slot is occupied.
   logic [PW-1:0] age_idx   [DEPTH];
   logic          age_valid [DEPTH];

   assign bus.full    = (count_reg == (PW+1)'(DEPTH));
   assign bus.ram_req = (count_reg != '0);
   assign enq         = bus.memwriteM && (bus.ampM != '0) && !bus.full;
   assign deq         = bus.ram_req && bus.ram_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (deq) rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({enq, deq})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Payload needs no reset: occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (enq) begin
         waddr_mem[wr_ptr_reg] <= bus.addrM[AW-1:2];
         data_mem[wr_ptr_reg]  <= bus.wdataM;
         be_mem[wr_ptr_reg]    <= bus.ampM;
      end
   end

   assign bus.ram_raddr = bus.addrM;
   assign bus.ram_addr  = {waddr_mem[rd_ptr_reg], 2'b00};
   assign bus.ram_wdata = data_mem[rd_ptr_reg];
   assign bus.ram_be    = be_mem[rd_ptr_reg];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_age
         assign age_idx[gi]   = rd_ptr_reg + PW'(gi);
         assign age_valid[gi] = ((PW+1)'(gi) < count_reg);
      end

      for (gi = 0; gi < NL; gi++) begin : g_lane
         logic [7:0] lane;
         // Walk oldest to youngest so the youngest matching store wins the lane.
         always_comb begin
            lane = bus.ram_rdata[8*gi +: 8];
            for (int k = 0; k < DEPTH; k++) begin
               if (age_valid[k] &&
                   (waddr_mem[age_idx[k]] == bus.addrM[AW-1:2]) &&
                   be_mem[age_idx[k]][gi]) begin
                  lane = data_mem[age_idx[k]][8*gi +: 8];
               end
            end
         end
         assign bus.rdataM[8*gi +: 8] = lane;
      end
   endgenerate
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed plus randomized bench for dmem_store_buffer against a queue-based model
// of pending stores and an image of the RAM contents.
module tb_dmem_store_buffer;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   dmem_store_buffer_if #(.AW(32), .DW(32)) bus ();

   dmem_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Backing RAM stand-in: 64 words, async read, byte-enabled write on handshake.
   logic [31:0] ram_mem [64];
   assign bus.ram_rdata = ram_mem[bus.ram_raddr[7:2]];
   always @(posedge clk) begin
      if (bus.ram_req && bus.ram_ready) begin
         for (int l = 0; l < 4; l++)
            if (bus.ram_be[l]) ram_mem[bus.ram_addr[7:2]][8*l +: 8] <= bus.ram_wdata[8*l +: 8];
      end
   end

   typedef struct {
      logic [29:0] w;
      logic [31:0] d;
      logic [3:0]  be;
   } ent_t;

   ent_t        q[$];
   logic [31:0] model_mem [64];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] a);
      logic [31:0] r;
      r = model_mem[a[7:2]];
      foreach (q[i])
         if (q[i].w == a[31:2])
            for (int l = 0; l < 4; l++)
               if (q[i].be[l]) r[8*l +: 8] = q[i].d[8*l +: 8];
      return r;
   endfunction

   task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] amp, input logic rdy);
      bus.memwriteM = we;
      bus.addrM     = a;
      bus.wdataM    = d;
      bus.ampM      = amp;
      bus.ram_ready = rdy;
   endtask

   // One cycle: check outputs against the model, clock, then advance the model.
   task automatic tick();
      bit fm, en, de;
      #1;
      fm = (q.size() == DEPTH);
      chk("full", 32'(bus.full), 32'(fm));
      chk("ram_req", 32'(bus.ram_req), 32'(q.size() != 0));
      if (q.size() != 0) begin
         chk("ram_addr", bus.ram_addr, {q[0].w, 2'b00});
         chk("ram_wdata", bus.ram_wdata, q[0].d);
         chk("ram_be", 32'(bus.ram_be), 32'(q[0].be));
      end
      chk("rdataM", bus.rdataM, merge(bus.addrM));
      en = bus.memwriteM && (bus.ampM != 4'b0) && !fm;
      de = (q.size() != 0) && bus.ram_ready;
      $display("cycle t=%0t we=%0b addr=%h wdata=%h amp=%b rdy=%0b rdata=%h full=%0b depth=%0d",
               $time, bus.memwriteM, bus.addrM, bus.wdataM, bus.ampM, bus.ram_ready,
               bus.rdataM, bus.full, q.size());
      @(posedge clk);
      if (de) begin
         for (int l = 0; l < 4; l++)
            if (q[0].be[l]) model_mem[q[0].w[5:0]][8*l +: 8] = q[0].d[8*l +: 8];
         void'(q.pop_front());
      end
      if (en) q.push_back('{bus.addrM[31:2], bus.wdataM, bus.ampM});
      @(negedge clk);
   endtask

   task automatic drain();
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
      for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) tick();
      chk("drained", 32'(q.size()), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         ram_mem[i]   = $urandom;
         model_mem[i] = ram_mem[i];
      end
      ram_mem[4] = 32'hAABBCCDD;
      model_mem[4] = 32'hAABBCCDD;
      reset = 1'b1;
      drive(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_rdata", bus.rdataM, 32'hAABBCCDD);
      chk("rst_req", 32'(bus.ram_req), 32'd0);
      chk("rst_full", 32'(bus.full), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Reset mid-drain with three queued stores
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h40 + 32'(4 * i), $urandom, 4'hF, 1'b0);
         tick();
      end
      drive(1'b0, 32'h40, 32'h0, 4'h0, 1'b1);
      #1;
      chk("pre_rst_req", 32'(bus.ram_req), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      q.delete();
      chk("mid_rst_req", 32'(bus.ram_req), 32'd0);
      chk("mid_rst_full", 32'(bus.full), 32'd0);
      chk("mid_rst_rdata", bus.rdataM, ram_mem[16]);
      @(negedge clk);
      reset = 1'b0;
      tick();

      // Byte and halfword stores merged over a zero RAM word
      ram_mem[4] = 32'h0;
      model_mem[4] = 32'h0;
      drive(1'b1, 32'h10, 32'h00000011, 4'b0001, 1'b0); tick();
      drive(1'b1, 32'h12, 32'h22330000, 4'b1100, 1'b0); tick();
      drive(1'b0, 32'h10, 32'h0, 4'b0000, 1'b0);
      #1;
      chk("merge_sb_sh", bus.rdataM, 32'h22330011);
      tick();
      drain();

      // Two stores to one word: youngest forwarded, both drained in order
      drive(1'b1, 32'h20, 32'h11111111, 4'hF, 1'b0); tick();
      drive(1'b1, 32'h20, 32'h22222222, 4'hF, 1'b0); tick();
      drive(1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
      #1;
      chk("youngest_fwd", bus.rdataM, 32'h22222222);
      chk("first_drain", bus.ram_wdata, 32'h11111111);
      tick();
      #1;
      chk("second_drain", bus.ram_wdata, 32'h22222222);
      drain();
      chk("ram_after", ram_mem[8], 32'h22222222);

      // Fill to full; fifth store refused until a slot frees
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h80 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF, 1'b0);
         tick();
      end
      chk("full_after4", 32'(bus.full), 32'd1);
      chk("held_at4", 32'(q.size()), 32'd4);
      drive(1'b1, 32'h90, 32'hC0DE0004, 4'hF, 1'b1); tick();
      drive(1'b1, 32'h90, 32'hC0DE0004, 4'hF, 1'b0); tick();
      #1;
      chk("fifth_accepted", 32'(bus.full), 32'd1);
      drain();
      chk("ram_fifth", ram_mem[36], 32'hC0DE0004);

      // Steady enqueue+dequeue across 2*DEPTH stores
      for (int i = 0; i < 2 * DEPTH; i++) begin
         drive(1'b1, 32'hA0 + 32'(4 * (i % 3)), $urandom, 4'(1 + i % 15), 1'b1);
         tick();
         chk("steady_count", 32'(q.size()), 32'd1);
      end
      drain();

      // Zero byte-enable store is a no-op; same-cycle store not forwarded
      drive(1'b1, 32'h30, 32'hDEADBEEF, 4'h0, 1'b0);
      tick();
      chk("amp0_noentry", 32'(bus.ram_req), 32'd0);
      drive(1'b1, 32'h30, 32'hFEEDFACE, 4'hF, 1'b0);
      #1;
      chk("no_same_cycle_fwd", bus.rdataM, ram_mem[12]);
      tick();
      drive(1'b0, 32'h30, 32'h0, 4'h0, 1'b0);
      #1;
      chk("next_cycle_fwd", bus.rdataM, 32'hFEEDFACE);
      drain();

      // Randomized traffic over a small address window
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 1)), {24'h0, 4'($urandom_range(0, 7)), 4'($urandom)},
               $urandom, 4'($urandom), 1'($urandom_range(0, 2) != 0));
         tick();
      end
      drain();
      for (int i = 0; i < 64; i++) chk("ram_image", ram_mem[i], model_mem[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
